// File: rtl/counter_run_sched.sv
// counter_run_sched: round-robin scheduler sharing one up-counter among NREQ run requesters
module counter_run_sched #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [3:0]            result,
  output logic                  result_ovf,
  output logic                  cnt_reset,
  output logic                  cnt_enable,
  input  logic [3:0]            cnt_value,
  input  logic                  cnt_overflow
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, DONE} state_t;
  state_t state, nxt;
  logic [IDW-1:0] ptr, idx, win, j;
  logic [LEN_W-1:0] run_len, down;
  logic any;
  // descending scan so the closest set bit at or after ptr is written last
  always_comb begin
    win = '0;
    any = 1'b0;
    j = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        win = j;
        any = 1'b1;
      end
    end
  end
  always_comb begin
    nxt = state == IDLE   ? (any ? CLEAR : IDLE) :
          state == CLEAR  ? (run_len == '0 ? SETTLE : RUN) :
          state == RUN    ? (down == LEN_W'(1) ? SETTLE : RUN) :
          state == SETTLE ? DONE : IDLE;
    busy = state != IDLE;
    done = state == DONE;
    cnt_reset = reset || state == CLEAR;
    cnt_enable = !reset && state == RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      idx <= '0;
      run_len <= '0;
      down <= '0;
      grant <= '0;
      done_id <= '0;
      result <= '0;
      result_ovf <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && any) begin
        idx <= win;
        run_len <= req_len[int'(win)*LEN_W +: LEN_W];
        grant <= NREQ'(1) << win;
        ptr <= win == IDW'(NREQ-1) ? '0 : win + 1'b1;
      end
      if (state == CLEAR) down <= run_len;
      if (state == RUN) down <= down - 1'b1;
      // counter has settled by SETTLE, so results are valid alongside done
      if (state == SETTLE) begin
        result <= cnt_value;
        result_ovf <= cnt_overflow;
        done_id <= idx;
      end
      if (state == DONE) grant <= '0;
    end
  end
endmodule

// File: tb/tb_counter_run_sched.sv
// tb_counter_run_sched: directed checks of the run scheduler against a step-2 counter model
module tb_counter_run_sched;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req;
  logic [15:0] req_len;
  logic [3:0] grant;
  logic busy, done, result_ovf, cnt_reset, cnt_enable, cnt_overflow;
  logic [1:0] done_id;
  logic [3:0] result, cnt_value;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  counter_run_sched dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len), .grant(grant),
    .busy(busy), .done(done), .done_id(done_id), .result(result),
    .result_ovf(result_ovf), .cnt_reset(cnt_reset), .cnt_enable(cnt_enable),
    .cnt_value(cnt_value), .cnt_overflow(cnt_overflow)
  );
  // 4-bit counter stepping by 2 with sticky overflow
  always @(posedge clk) begin
    if (cnt_reset) begin
      cnt_value <= 4'd0;
      cnt_overflow <= 1'b0;
    end else if (cnt_enable) begin
      cnt_value <= cnt_value + 4'd2;
      cnt_overflow <= cnt_overflow | (cnt_value > 4'd13);
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_run(input int eg, input int elen, input int eid, input int eres,
                        input int eovf, input bit mut);
    int t, gc, ec, dc;
    t = 0;
    while (grant == 4'd0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("grant", grant, eg);
    gc = 0;
    ec = 0;
    dc = 0;
    while (grant != 4'd0 && gc < 50) begin
      if (cnt_enable) ec++;
      if (busy != 1'b1) check("busy_run", busy, 1);
      if (done) begin
        dc++;
        check("done_id", done_id, eid);
        check("result", result, eres);
        check("result_ovf", result_ovf, eovf);
      end
      if (mut && gc == 2) begin
        req = 4'd0;
        req_len = 16'hffff;
      end
      gc++;
      @(negedge clk);
    end
    check("grant_cycles", gc, elen + 3);
    check("enable_cycles", ec, elen);
    check("done_pulses", dc, 1);
    check("busy_idle", busy, 0);
    req = 4'd0;
  endtask
  initial begin
    reset = 1'b1;
    req = 4'd0;
    req_len = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cnt_reset", cnt_reset, 1);
    check("rst_cnt_enable", cnt_enable, 0);
    reset = 1'b0;
    req_len = 16'h0003;
    req = 4'b0001;
    do_run(1, 3, 0, 6, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_len = 16'h1111;
    req = 4'b1111;
    do_run(1, 1, 0, 2, 0, 1'b0);
    req = 4'b1111;
    do_run(2, 1, 1, 2, 0, 1'b0);
    req = 4'b1111;
    do_run(4, 1, 2, 2, 0, 1'b0);
    req = 4'b1111;
    do_run(8, 1, 3, 2, 0, 1'b0);
    req = 4'b1111;
    do_run(1, 1, 0, 2, 0, 1'b0);
    req_len = 16'h0000;
    req = 4'b0100;
    do_run(4, 0, 2, 0, 0, 1'b0);
    req_len = 16'h0080;
    req = 4'b0010;
    do_run(2, 8, 1, 0, 1, 1'b0);
    req_len = 16'h0020;
    req = 4'b0010;
    do_run(2, 2, 1, 4, 0, 1'b0);
    req_len = 16'h5002;
    req = 4'b1000;
    for (int t = 0; t < 50 && grant == 4'd0; t++) @(negedge clk);
    check("abort_grant", grant, 8);
    repeat (2) @(negedge clk);
    check("abort_enable", cnt_enable, 1);
    reset = 1'b1;
    req = 4'b1001;
    @(negedge clk);
    check("abort_grant0", grant, 0);
    check("abort_cnt_reset", cnt_reset, 1);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_ovf", result_ovf, 0);
    check("abort_id", done_id, 0);
    reset = 1'b0;
    do_run(1, 2, 0, 4, 0, 1'b0);
    req_len = 16'h0400;
    req = 4'b0100;
    do_run(4, 4, 2, 8, 0, 1'b1);
    repeat (3) @(negedge clk);
    check("final_grant", grant, 0);
    check("final_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/counter_run_sched.md
Name: counter_run_sched

Overview:
- Round-robin scheduler that shares one 4-bit up-counter datapath among NREQ requesters.
- Each requester asks for a "run" of N enable cycles.
- For each granted run, the scheduler clears the counter, enables it for exactly N cycles, then captures the final count and overflow flag and returns them with a done pulse.
- Sits between client logic and the counter: drives the counter's reset/enable, observes its value/overflow.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LEN_W, 4, width of each requested run length.
- IDW, 2, width of requester index (must satisfy 2**IDW >= NREQ).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester run request, level.
- req_len  in  NREQ*LEN_W  run length per requester; slice i = bits [i*LEN_W +: LEN_W].
- grant  out  NREQ  one-hot grant, held for the whole run.
- busy  out  1  high whenever FSM is not IDLE.
- done  out  1  one-cycle pulse, run complete.
- done_id  out  IDW  index of completed requester, valid with done, held until next done.
- result  out  4  captured counter value, held until next done.
- result_ovf  out  1  captured overflow flag, held until next done.
- cnt_reset  out  1  drives counter reset.
- cnt_enable  out  1  drives counter enable.
- cnt_value  in  4  counter output.
- cnt_overflow  in  1  counter overflow flag.

Behaviour:
- reset (sync, active-high; clock clk):
  - FSM=IDLE, grant=0, busy=0, done=0, done_id=0, result=0, result_ovf=0.
  - cnt_reset=1 while reset is high; cnt_enable=0.
  - RR pointer=0 (requester 0 highest priority first).
- States: IDLE, CLEAR, RUN, SETTLE, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit searching from the RR pointer upward with wrap.
  - Register its index and req_len slice (run_len), set grant one-hot, go to CLEAR.
  - RR pointer becomes winner+1 mod NREQ.
  - No req: stay in IDLE; outputs other than held results are 0.
- CLEAR: cnt_reset=1, cnt_enable=0 for exactly one cycle.
  - run_len==0: go to SETTLE.
  - Otherwise: load a down-counter with run_len and go to RUN.
- RUN: cnt_enable=1 every cycle.
  - Decrement the down-counter each cycle.
  - Leave for SETTLE after exactly run_len cycles of enable.
- SETTLE: cnt_enable=0, cnt_reset=0 for one cycle, so the counter's last registered update is visible.
- DONE (one cycle):
  - result<=cnt_value, result_ovf<=cnt_overflow, done_id<=index, done=1.
  - grant cleared on the exit edge; go to IDLE.
- Latency:
  - grant rises on the edge entering CLEAR.
  - done is high in cycle run_len+2 after CLEAR; i.e. grant high for run_len+3 cycles.
  - Back-to-back runs: at least one IDLE cycle between done and the next grant.
- req_len is sampled only at grant; later changes are ignored.
- req deassertion:
  - After grant: ignored, the run completes.
  - Before grant: the requester simply loses eligibility.
- Simultaneous requests: strict RR. Requester i with req held continuously waits at most NREQ-1 other runs.
- Arithmetic: down-counter width LEN_W; no wrap in the scheduler. Counter wrap/overflow semantics belong to the counter; the scheduler only samples them.
- Reset mid-run:
  - Run aborted, no done pulse, grant=0 next cycle.
  - result/result_ovf/done_id return to 0.
- Invariants: grant is one-hot or zero; grant!=0 iff FSM in CLEAR/RUN/SETTLE/DONE; busy==|grant.

Test Plan:
- Reset then req=0001, len0=3, with bench step-2 counter model → grant=0001 for 6 cycles; cnt_enable high 3 cycles; done with done_id=0, result=6, result_ovf=0.
- req=1111 held, all lens=1 → grants in order 0001, 0010, 0100, 1000, 0001; each run 4 cycles; one IDLE cycle between runs.
- len2=0 on requester 2 → CLEAR then SETTLE, no cnt_enable pulses; result=0, done after 3 grant cycles.
- Bench counter model asserts cnt_overflow during a len=8 run → result_ovf=1, result equals the model's wrapped value; a following len=2 run gives result_ovf=0 (counter cleared in CLEAR).
- Reset asserted in RUN cycle 2 of a len=5 run → no done, grant=0, cnt_reset=1, result=0; the next req is served from requester 0.
- len changed, or req dropped, mid-run → run still uses the sampled len and completes with done.
